// File: rtl/note_sequencer.sv
// Single-voice pattern player: fetches {end, pitch, duration} entries from a
// synchronous ROM, loads the external duration counter and drives pitch/gate.
//
// state  | meaning
// IDLE   | waiting for start; outputs quiet
// FETCH  | ROM read issued at current address
// DECODE | ROM data valid; load note or handle end marker
// PLAY   | note sounding until the duration counter reports done
module note_sequencer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int PITCH_WIDTH = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [ADDR_WIDTH-1:0]  i_start_addr,
  input  logic                   i_stop,
  input  logic                   i_loop,
  output logic [ADDR_WIDTH-1:0]  o_rom_addr,
  output logic                   o_rom_rd,
  input  logic [PITCH_WIDTH+5:0] i_rom_data,
  output logic                   o_dur_load,
  output logic [4:0]             o_duration,
  input  logic                   i_dur_done,
  output logic                   o_dur_clear,
  output logic [PITCH_WIDTH-1:0] o_pitch,
  output logic                   o_gate,
  output logic                   o_note_strobe,
  output logic                   o_busy,
  output logic                   o_finished
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DECODE, S_PLAY} state_t;

  state_t                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH-1:0]  start_addr_q;
  logic [PITCH_WIDTH-1:0] pitch_q;
  logic                   gate_q;
  logic                   note_strobe_q;
  logic                   finished_q;
  logic                   dur_clear_q;

  logic                   end_mark;
  logic [PITCH_WIDTH-1:0] rom_pitch;

  assign end_mark  = i_rom_data[PITCH_WIDTH+5];
  assign rom_pitch = i_rom_data[PITCH_WIDTH+4:5];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      start_addr_q  <= '0;
      pitch_q       <= '0;
      gate_q        <= 1'b0;
      note_strobe_q <= 1'b0;
      finished_q    <= 1'b0;
      dur_clear_q   <= 1'b0;
    end else begin
      note_strobe_q <= 1'b0;
      finished_q    <= 1'b0;
      dur_clear_q   <= 1'b0;
      if (i_stop && state_q != S_IDLE) begin
        // Counter only holds a live duration once DECODE has issued a load.
        state_q     <= S_IDLE;
        pitch_q     <= '0;
        gate_q      <= 1'b0;
        dur_clear_q <= (state_q == S_PLAY) || (state_q == S_DECODE && !end_mark);
      end else begin
        case (state_q)
          S_IDLE: begin
            if (i_start && !i_stop) begin
              addr_q       <= i_start_addr;
              start_addr_q <= i_start_addr;
              state_q      <= S_FETCH;
            end
          end
          S_FETCH: state_q <= S_DECODE;
          S_DECODE: begin
            if (end_mark) begin
              // An end marker at the start address means an empty pattern.
              if (i_loop && addr_q != start_addr_q) begin
                addr_q  <= start_addr_q;
                state_q <= S_FETCH;
              end else begin
                state_q    <= S_IDLE;
                pitch_q    <= '0;
                gate_q     <= 1'b0;
                finished_q <= 1'b1;
              end
            end else begin
              pitch_q       <= rom_pitch;
              gate_q        <= (rom_pitch != '0);
              note_strobe_q <= 1'b1;
              addr_q        <= addr_q + ADDR_WIDTH'(1);
              state_q       <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (i_dur_done) state_q <= S_FETCH;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o_rom_addr    = addr_q;
  assign o_rom_rd      = (state_q == S_FETCH);
  assign o_dur_load    = (state_q == S_DECODE) && !end_mark;
  assign o_duration    = i_rom_data[4:0];
  assign o_dur_clear   = dur_clear_q;
  assign o_pitch       = pitch_q;
  assign o_gate        = gate_q;
  assign o_note_strobe = note_strobe_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_finished    = finished_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: pattern walk model feeds expected
// queues, a negedge monitor pops and compares as the DUT emits events.
module tb_note_sequencer;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [7:0]  i_start_addr;
  logic        i_stop;
  logic        i_loop;
  logic [7:0]  o_rom_addr;
  logic        o_rom_rd;
  logic [11:0] i_rom_data;
  logic        o_dur_load;
  logic [4:0]  o_duration;
  logic        i_dur_done;
  logic        o_dur_clear;
  logic [5:0]  o_pitch;
  logic        o_gate;
  logic        o_note_strobe;
  logic        o_busy;
  logic        o_finished;

  note_sequencer #(.ADDR_WIDTH(8), .PITCH_WIDTH(6)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_start_addr(i_start_addr),
    .i_stop(i_stop), .i_loop(i_loop), .o_rom_addr(o_rom_addr), .o_rom_rd(o_rom_rd),
    .i_rom_data(i_rom_data), .o_dur_load(o_dur_load), .o_duration(o_duration),
    .i_dur_done(i_dur_done), .o_dur_clear(o_dur_clear), .o_pitch(o_pitch),
    .o_gate(o_gate), .o_note_strobe(o_note_strobe), .o_busy(o_busy),
    .o_finished(o_finished)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  logic [11:0] rom [256];
  always @(posedge i_clk) if (o_rom_rd) i_rom_data <= rom[o_rom_addr];

  // Duration counter: D lasts D+1 ticks, cleared by reset or abort.
  logic [4:0] cnt_q;
  logic       cnt_act_q;
  always @(posedge i_clk) begin
    if (i_rst || o_dur_clear) cnt_act_q <= 1'b0;
    else if (o_dur_load) begin cnt_q <= o_duration; cnt_act_q <= 1'b1; end
    else if (cnt_act_q) begin
      if (cnt_q == 5'd0) cnt_act_q <= 1'b0;
      else cnt_q <= cnt_q - 5'd1;
    end
  end
  assign i_dur_done = cnt_act_q && (cnt_q == 5'd0);

  typedef struct { bit fin; int pitch; int dur; } note_t;
  note_t exp_q[$];
  int    addr_exp_q[$];

  int tests = 0;
  int fails = 0;
  bit sb_en = 0;
  int strobes_seen = 0;
  bit pend = 0;
  int pend_pitch = 0;
  bit prev_load = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input int act);
    tests++;
    fails++;
    $display("FAIL %s: got event/value %0d expected none", name, act);
  endtask

  always @(negedge i_clk) begin
    note_t e;
    if (o_dur_load && prev_load) flag("load_consecutive", 1);
    prev_load = o_dur_load;
    if (sb_en && !i_rst) begin
      if (o_rom_rd) begin
        if (addr_exp_q.size() == 0) flag("rom_addr_extra", o_rom_addr);
        else check("rom_addr", o_rom_addr, addr_exp_q.pop_front());
      end
      if (pend) begin
        check("note_strobe", o_note_strobe, 1);
        check("pitch", o_pitch, pend_pitch);
        check("gate", o_gate, pend_pitch != 0);
        strobes_seen++;
        pend = 0;
      end else if (o_note_strobe) flag("spurious_strobe", o_pitch);
      if (o_dur_load) begin
        if (exp_q.size() == 0 || exp_q[0].fin) flag("unexpected_load", o_duration);
        else begin
          e = exp_q.pop_front();
          check("duration", o_duration, e.dur);
          pend_pitch = e.pitch;
          pend = 1;
        end
      end
      if (o_finished) begin
        if (exp_q.size() == 0 || !exp_q[0].fin) flag("unexpected_finished", 1);
        else begin
          e = exp_q.pop_front();
          check("finished_pitch", o_pitch, 0);
          check("finished_gate", o_gate, 0);
        end
      end
    end
  end

  // Walks the pattern from sa by the playback rules; returns notes in first pass.
  task automatic model_pattern(input logic [7:0] sa, input bit lp, output int n1);
    logic [7:0] a;
    note_t n;
    int passes;
    n1 = 0;
    passes = 1;
    for (int p = 0; p < passes; p++) begin
      a = sa;
      for (int k = 0; k < 256; k++) begin
        addr_exp_q.push_back(a);
        if (rom[a][11]) break;
        n.fin = 0; n.pitch = rom[a][10:5]; n.dur = rom[a][4:0];
        exp_q.push_back(n);
        if (p == 0) n1++;
        a = a + 8'd1;
      end
      if (p == 0 && lp && a != sa) passes = 2;
    end
    n.fin = 1; n.pitch = 0; n.dur = 0;
    exp_q.push_back(n);
  endtask

  task automatic run_pattern(input logic [7:0] sa, input bit lp);
    int n1;
    int cyc;
    exp_q.delete();
    addr_exp_q.delete();
    model_pattern(sa, lp, n1);
    strobes_seen = 0;
    pend = 0;
    @(negedge i_clk);
    sb_en = 1;
    i_start_addr = sa; i_loop = lp; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    cyc = 0;
    // Second pass must finish: drop loop once the replay has begun.
    while (o_busy && cyc < 3000) begin
      if (lp && strobes_seen >= n1 + 1) i_loop = 1'b0;
      @(negedge i_clk);
      cyc++;
    end
    if (cyc >= 3000) flag("timeout_busy", cyc);
    repeat (2) @(negedge i_clk);
    check("exp_queue_left", exp_q.size(), 0);
    check("addr_queue_left", addr_exp_q.size(), 0);
    sb_en = 0;
    i_loop = 1'b0;
  endtask

  task automatic wait_strobe(input string name);
    int cyc = 0;
    while (!o_note_strobe && cyc < 200) begin @(negedge i_clk); cyc++; end
    if (cyc >= 200) flag(name, cyc);
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (o_busy && cyc < 500) begin @(negedge i_clk); cyc++; end
    if (cyc >= 500) flag("timeout_idle", cyc);
  endtask

  initial begin
    int cyc;
    logic [11:0] endw;
    endw = 12'h800;
    i_rst = 1'b1; i_start = 0; i_start_addr = 0; i_stop = 0; i_loop = 0;
    for (int i = 0; i < 256; i++) rom[i] = endw;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_busy", o_busy, 0);
    check("rst_gate", o_gate, 0);
    check("rst_pitch", o_pitch, 0);
    check("rst_rom_addr", o_rom_addr, 0);
    check("rst_rom_rd", o_rom_rd, 0);
    check("rst_strobes", {o_note_strobe, o_finished, o_dur_clear}, 0);

    rom[4] = {1'b0, 6'd5, 5'd2};
    rom[5] = {1'b0, 6'd0, 5'd0};
    run_pattern(8'd4, 1'b0);
    run_pattern(8'd4, 1'b1);
    run_pattern(8'd9, 1'b1);
    rom[255] = {1'b0, 6'd3, 5'd1};
    run_pattern(8'd255, 1'b0);

    // Abort during a long note, then restart one cycle later.
    rom[20] = {1'b0, 6'd5, 5'd31};
    @(negedge i_clk);
    i_start_addr = 8'd20; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_strobe("timeout_strobe_stop");
    repeat (3) @(negedge i_clk);
    i_stop = 1'b1;
    @(negedge i_clk);
    i_stop = 1'b0;
    check("stop_busy", o_busy, 0);
    check("stop_gate", o_gate, 0);
    check("stop_pitch", o_pitch, 0);
    check("stop_dur_clear", o_dur_clear, 1);
    check("stop_no_finished", o_finished, 0);
    @(negedge i_clk);
    check("stop_dur_clear_1cyc", o_dur_clear, 0);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    check("restart_rd", o_rom_rd, 1);
    check("restart_addr", o_rom_addr, 20);
    @(negedge i_clk);
    check("restart_load", o_dur_load, 1);
    check("restart_dur", o_duration, 31);
    i_stop = 1'b1;
    @(negedge i_clk);
    i_stop = 1'b0;
    check("stop_decode_clear", o_dur_clear, 1);
    wait_idle();

    // Start and stop together in IDLE: nothing happens.
    i_start_addr = 8'd4; i_start = 1'b1; i_stop = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0; i_stop = 1'b0;
    check("startstop_busy", o_busy, 0);
    check("startstop_rd", o_rom_rd, 0);
    @(negedge i_clk);
    check("startstop_busy2", o_busy, 0);

    // Start while playing is ignored; playback continues at 21.
    i_start_addr = 8'd20; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_strobe("timeout_strobe_busy");
    i_start_addr = 8'd50; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    cyc = 0;
    while (!o_rom_rd && cyc < 100) begin @(negedge i_clk); cyc++; end
    if (cyc >= 100) flag("timeout_next_fetch", cyc);
    check("busy_start_ignored_addr", o_rom_addr, 21);
    wait_idle();

    // Reset mid-note.
    i_start_addr = 8'd20; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_strobe("timeout_strobe_rst");
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("midrst_busy", o_busy, 0);
    check("midrst_gate", o_gate, 0);
    check("midrst_pitch", o_pitch, 0);
    check("midrst_addr", o_rom_addr, 0);
    check("midrst_strobes", {o_note_strobe, o_finished, o_dur_clear, o_dur_load}, 0);
    repeat (2) @(negedge i_clk);

    for (int r = 0; r < 30; r++) begin
      if (r % 5 == 0) begin
        for (int i = 0; i < 256; i++) begin
          if (i % 8 == 7 || $urandom_range(0, 4) == 0) rom[i] = endw;
          else rom[i] = {1'b0,
                         ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
                         5'($urandom_range(0, 6))};
        end
      end
      run_pattern(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
